// File: rtl/bp_gshare_pkg.sv
// Shared defaults and helpers for the gshare predictor and its BTB.
package bp_gshare_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int BTB_IDX_W_DEF = 6;
  localparam int PHT_IDX_W_DEF = 8;
  localparam int GHR_W_DEF     = 8;
  localparam int CTR_W_DEF     = 2;

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic int unsigned bp_ctr_reset(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_gshare_btb_dm.sv
// Direct-mapped branch target buffer: one combinational read port, one synchronous write port.
module bp_btb_dm #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_hit,
  output logic [XLEN-1:0] rd_tgt,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_tgt
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = XLEN - 2 - IDX_W;

  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             unused_ok;

  assign rd_idx    = rd_pc[IDX_W+1:2];
  assign wr_idx    = wr_pc[IDX_W+1:2];
  assign rd_hit    = vld_q[rd_idx] && (tag_q[rd_idx] == rd_pc[XLEN-1:IDX_W+2]);
  assign rd_tgt    = tgt_q[rd_idx];
  assign unused_ok = &{1'b0, rd_pc[1:0], wr_pc[1:0]};

  // Only valid bits need reset; tag/target are don't-care until validated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_q         <= '0;
    else if (wr_en) vld_q[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_pc[XLEN-1:IDX_W+2];
      tgt_q[wr_idx] <= wr_tgt;
    end
  end

endmodule

// File: rtl/bp_gshare.sv
// Gshare direction predictor with direct-mapped BTB; fetch-side prediction and
// execute-side resolve, training, history repair and flush generation.
module bp_gshare
  import bp_gshare_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int BTB_IDX_W = BTB_IDX_W_DEF,
  parameter int PHT_IDX_W = PHT_IDX_W_DEF,
  parameter int GHR_W     = GHR_W_DEF,
  parameter int CTR_W     = CTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc_f,
  input  logic [XLEN-1:0]  pc4_f,
  input  logic             is_br_f,
  input  logic             stall_f,
  output logic [GHR_W-1:0] ghr_f,
  output logic             pred_tkn_f,
  input  logic [XLEN-1:0]  pc_d,
  input  logic             br_e,
  input  logic [XLEN-1:0]  pc_e,
  input  logic [XLEN-1:0]  pc4_e,
  input  logic             tkn_e,
  input  logic [XLEN-1:0]  tgt_e,
  input  logic [GHR_W-1:0] ghr_e,
  output logic [XLEN-1:0]  next_pc,
  output logic             flush,
  output logic [31:0]      mispred_cnt
);
  localparam int                PHT_N   = 1 << PHT_IDX_W;
  localparam logic [CTR_W-1:0]  CTR_RST = CTR_W'(bp_ctr_reset(CTR_W));
  localparam logic [CTR_W-1:0]  CTR_MAX = '1;

  logic [CTR_W-1:0]     pht_q [PHT_N];
  logic [GHR_W-1:0]     ghr_q;
  logic [PHT_IDX_W-1:0] pht_idx_f, pht_idx_e;
  logic [CTR_W-1:0]     ctr_f, ctr_e;
  logic                 btb_hit;
  logic [XLEN-1:0]      btb_tgt, pred_pc, exp_pc;

  bp_btb_dm #(.XLEN(XLEN), .IDX_W(BTB_IDX_W)) u_btb (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_pc  (pc_f),
    .rd_hit (btb_hit),
    .rd_tgt (btb_tgt),
    .wr_en  (br_e & tkn_e),
    .wr_pc  (pc_e),
    .wr_tgt (tgt_e)
  );

  assign pht_idx_f  = pc_f[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
  assign pht_idx_e  = pc_e[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_e);
  assign ctr_f      = pht_q[pht_idx_f];
  assign ctr_e      = pht_q[pht_idx_e];
  assign ghr_f      = ghr_q;
  assign pred_tkn_f = is_br_f & btb_hit & ctr_f[CTR_W-1];
  assign pred_pc    = pred_tkn_f ? btb_tgt : pc4_f;

  // Resolve: D already holds whatever fetch guessed after E; mismatch means wrong path.
  assign exp_pc  = tkn_e ? tgt_e : pc4_e;
  assign flush   = br_e & (pc_d != exp_pc);
  assign next_pc = flush ? exp_pc : pred_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_RST;
    end else if (br_e) begin
      if (tkn_e && ctr_e != CTR_MAX)      pht_q[pht_idx_e] <= ctr_e + 1'b1;
      else if (!tkn_e && ctr_e != '0)     pht_q[pht_idx_e] <= ctr_e - 1'b1;
    end
  end

  // Repair from the E snapshot beats the speculative shift of a squashed fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q       <= '0;
      mispred_cnt <= '0;
    end else begin
      if (flush)                  ghr_q <= {ghr_e[GHR_W-2:0], tkn_e};
      else if (is_br_f && !stall_f) ghr_q <= {ghr_q[GHR_W-2:0], pred_tkn_f};
      if (flush) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_bp_gshare.sv
// Directed bench for bp_gshare: expectations queued per step and checked against DUT outputs.
module tb_bp_gshare;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f, pc4_f, pc_d, pc_e, pc4_e, tgt_e, next_pc, mispred_cnt;
  logic        is_br_f, stall_f, pred_tkn_f, br_e, tkn_e, flush;
  logic [7:0]  ghr_f, ghr_e;

  typedef struct {
    string       tag;
    logic [31:0] npc;
    logic        fl;
    logic        pr;
    logic [7:0]  gh;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bp_gshare dut (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pc4_f(pc4_f), .is_br_f(is_br_f),
    .stall_f(stall_f), .ghr_f(ghr_f), .pred_tkn_f(pred_tkn_f), .pc_d(pc_d),
    .br_e(br_e), .pc_e(pc_e), .pc4_e(pc4_e), .tkn_e(tkn_e), .tgt_e(tgt_e),
    .ghr_e(ghr_e), .next_pc(next_pc), .flush(flush), .mispred_cnt(mispred_cnt)
  );

  task automatic set_f(input logic [31:0] pc, input logic br, input logic st);
    pc_f = pc; pc4_f = pc + 32'd4; is_br_f = br; stall_f = st;
  endtask

  task automatic set_e(input logic br, input logic [31:0] pc, input logic tkn,
                       input logic [31:0] tgt, input logic [7:0] gh, input logic [31:0] pd);
    br_e = br; pc_e = pc; pc4_e = pc + 32'd4; tkn_e = tkn; tgt_e = tgt; ghr_e = gh; pc_d = pd;
  endtask

  task automatic idle_e();
    set_e(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0);
  endtask

  // Queue the expectation, let combinational outputs settle, then pop and compare.
  task automatic chk(input string tag, input logic [31:0] npc, input logic fl,
                     input logic pr, input logic [7:0] gh, input logic [31:0] cnt);
    exp_t e;
    sb.push_back('{tag, npc, fl, pr, gh, cnt});
    #1;
    e = sb.pop_front();
    checks++;
    assert (next_pc === e.npc) else begin
      failures++; $error("FAIL %s next_pc got=%h exp=%h", e.tag, next_pc, e.npc); end
    checks++;
    assert (flush === e.fl) else begin
      failures++; $error("FAIL %s flush got=%b exp=%b", e.tag, flush, e.fl); end
    checks++;
    assert (pred_tkn_f === e.pr) else begin
      failures++; $error("FAIL %s pred_tkn_f got=%b exp=%b", e.tag, pred_tkn_f, e.pr); end
    checks++;
    assert (ghr_f === e.gh) else begin
      failures++; $error("FAIL %s ghr_f got=%h exp=%h", e.tag, ghr_f, e.gh); end
    checks++;
    assert (mispred_cnt === e.cnt) else begin
      failures++; $error("FAIL %s mispred_cnt got=%0d exp=%0d", e.tag, mispred_cnt, e.cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_e();
    set_f(32'h100, 1'b1, 1'b0);
    chk("reset", 32'h104, 0, 0, 8'h00, 0);
    @(negedge clk) rst_n = 1'b1;
    set_f(32'h108, 1'b0, 1'b0);

    // First resolve of the loop branch: cold tables, so a flush to the target.
    @(negedge clk) set_e(1, 32'h100, 1, 32'h80, 8'h00, 32'h104);
    chk("loop_flush", 32'h80, 1, 0, 8'h00, 0);
    @(negedge clk) idle_e();
    chk("after_flush", 32'h10C, 0, 0, 8'h01, 1);

    // Shift in eight not-taken fetch branches to bring history back to zero.
    set_f(32'h200, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    set_f(32'h100, 1'b1, 1'b1);
    chk("loop_pred", 32'h80, 0, 1, 8'h00, 1);
    @(negedge clk) set_f(32'h80, 1'b0, 1'b0);
    set_e(1, 32'h100, 1, 32'h80, 8'h00, 32'h80);
    chk("loop_ok2", 32'h84, 0, 0, 8'h00, 1);
    @(negedge clk) chk("loop_ok3", 32'h84, 0, 0, 8'h00, 1);

    // Saturation at the top, then the floor, on PHT index 0xC0.
    set_f(32'h300, 1'b1, 1'b1);
    repeat (5) begin
      @(negedge clk) set_e(1, 32'h300, 1, 32'h400, 8'h00, 32'h400);
    end
    @(negedge clk) set_e(1, 32'h300, 0, 32'h400, 8'h00, 32'h304);
    @(negedge clk) idle_e();
    chk("sat_nt1", 32'h400, 0, 1, 8'h00, 1);
    @(negedge clk) set_e(1, 32'h300, 0, 32'h400, 8'h00, 32'h304);
    chk("rw_old", 32'h400, 0, 1, 8'h00, 1);
    @(negedge clk) idle_e();
    chk("sat_nt2", 32'h304, 0, 0, 8'h00, 1);
    repeat (3) begin
      @(negedge clk) set_e(1, 32'h300, 0, 32'h400, 8'h00, 32'h304);
    end
    @(negedge clk) set_e(1, 32'h300, 1, 32'h400, 8'h00, 32'h400);
    @(negedge clk) idle_e();
    chk("floor1", 32'h304, 0, 0, 8'h00, 1);
    set_e(1, 32'h300, 1, 32'h400, 8'h00, 32'h400);
    @(negedge clk) idle_e();
    chk("floor2", 32'h400, 0, 1, 8'h00, 1);

    // Alias pair: 0x504 trained taken under ghr 0x00, not-taken under ghr 0xFF.
    set_f(32'h508, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk) set_e(1, 32'h504, 1, 32'h600, 8'h00, 32'h600);
    end
    repeat (2) begin
      @(negedge clk) set_e(1, 32'h504, 0, 32'h600, 8'hFF, 32'h508);
    end
    @(negedge clk) idle_e();
    set_f(32'h504, 1'b1, 1'b1);
    chk("alias_g00", 32'h600, 0, 1, 8'h00, 1);

    // Speculative history: taken, not-taken, not-taken.
    @(negedge clk) set_f(32'h504, 1'b1, 1'b0);
    @(negedge clk) set_f(32'h200, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk) chk("spec_shift", 32'h204, 0, 0, 8'h04, 1);
    set_e(1, 32'h900, 1, 32'hA00, 8'h05, 32'h904);
    chk("flush_vs_fetch", 32'hA00, 1, 0, 8'h04, 1);
    @(negedge clk) idle_e();
    set_f(32'h200, 1'b1, 1'b1);
    chk("ghr_repair", 32'h204, 0, 0, 8'h0B, 2);
    @(negedge clk) chk("stall_hold", 32'h204, 0, 0, 8'h0B, 2);

    // Repair history to 0xFF, then look at the other alias entry.
    set_f(32'h200, 1'b0, 1'b0);
    set_e(1, 32'h700, 1, 32'h800, 8'h7F, 32'h704);
    chk("flush2", 32'h800, 1, 0, 8'h0B, 2);
    @(negedge clk) set_f(32'h504, 1'b1, 1'b1);
    set_e(1, 32'h504, 1, 32'h600, 8'hFF, 32'h600);
    chk("alias_gff", 32'h508, 0, 0, 8'hFF, 3);
    @(negedge clk) chk("alias_gff_ctr1", 32'h508, 0, 0, 8'hFF, 3);
    @(negedge clk) idle_e();
    chk("alias_gff_new", 32'h600, 0, 1, 8'hFF, 3);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    chk("async_rst", 32'h508, 0, 0, 8'h00, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) chk("post_rst", 32'h508, 0, 0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
